// File: rtl/align_shifter_pipe.sv
// -----------------------------------------------------------------------------
// align_shifter_pipe
//
// Pipelined mantissa alignment shifter for FP adder datapaths. The smaller
// operand's significand, extended by two zero bits, is right-shifted by the
// exponent difference. The shift amount is resolved a few bits per stage,
// starting with the most significant bits. Guard, round and sticky bits are
// produced for the rounding stage. An exponent difference too large for the
// shift field saturates the shift. An optional arithmetic mode fills the
// vacated bits with the sign bit.
//
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   in_valid / in_ready   input handshake
//   in_mant               significand to align (WIDTH bits)
//   in_shamt              low exponent-difference bits (SHAMT_W bits)
//   in_exp_hi             upper exponent-difference bits; any 1 saturates
//   in_arith              1 = sign fill, 0 = zero fill
//   in_tag                sideband tag carried with the operand
//   out_valid / out_ready output handshake
//   out_mant              aligned significand
//   out_guard, out_round  first and second bits below the out_mant LSB
//   out_sticky            OR of all discarded bits below the round bit
//   out_tag               tag of this result
// -----------------------------------------------------------------------------
module align_shifter_pipe #(
  parameter int WIDTH    = 24,
  parameter int SHAMT_W  = 5,
  parameter int EXP_HI_W = 3,
  parameter int LATENCY  = 2,
  parameter int TAG_W    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    in_mant,
  input  logic [SHAMT_W-1:0]  in_shamt,
  input  logic [EXP_HI_W-1:0] in_exp_hi,
  input  logic                in_arith,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    out_mant,
  output logic                out_guard,
  output logic                out_round,
  output logic                out_sticky,
  output logic [TAG_W-1:0]    out_tag
);

  localparam int W2  = WIDTH + 2;
  localparam int BPS = (SHAMT_W + LATENCY - 1) / LATENCY;
  localparam logic [SHAMT_W:0] W2_L = (SHAMT_W + 1)'(W2);

  // Shift-amount bits handled by stage k, MSB first. The final stage also
  // covers any remainder because BPS is rounded up.
  function automatic logic [SHAMT_W-1:0] stage_mask(input int k);
    logic [SHAMT_W-1:0] m;
    m = '0;
    for (int i = 0; i < SHAMT_W; i++) begin
      if ((i <= SHAMT_W - 1 - k * BPS) && (i >= SHAMT_W - (k + 1) * BPS)) begin
        m[i] = 1'b1;
      end
    end
    return m;
  endfunction

  // Per-slot state
  logic [W2-1:0]      r_q   [LATENCY];
  logic               st_q  [LATENCY];
  logic [SHAMT_W-1:0] sh_q  [LATENCY];
  logic               sat_q [LATENCY];
  logic               ar_q  [LATENCY];
  logic [TAG_W-1:0]   tag_q [LATENCY];

  logic [LATENCY-1:0] valid_q, valid_d;
  logic [LATENCY-1:0] adv;
  logic [LATENCY-1:0] load;
  logic               ready_c;

  // Advance chain, walked from the output back to the input. ready_c means
  // "the slot downstream of k can take a new operand this cycle".
  always_comb begin
    adv     = '0;
    load    = '0;
    valid_d = valid_q;
    ready_c = out_ready;
    for (int k = LATENCY - 1; k >= 0; k--) begin
      adv[k]  = valid_q[k] & ready_c;
      ready_c = !valid_q[k] | adv[k];
    end
    load[0] = in_valid & ready_c;
    for (int k = 1; k < LATENCY; k++) begin
      load[k] = adv[k-1];
    end
    for (int k = 0; k < LATENCY; k++) begin
      valid_d[k] = load[k] | (valid_q[k] & !adv[k]);
    end
  end

  assign in_ready = ready_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LATENCY; gi++) begin : g_stage
      localparam logic [SHAMT_W-1:0] MASK = stage_mask(gi);

      logic [W2-1:0]      src_r;
      logic               src_st;
      logic [SHAMT_W-1:0] src_sh;
      logic               src_sat;
      logic               src_ar;
      logic [TAG_W-1:0]   src_tag;

      if (gi == 0) begin : g_first
        logic sat0;
        // Saturation is decided once, here. A saturated operand is finished
        // immediately. The remaining stages pass it through unshifted.
        always_comb begin
          sat0    = (|in_exp_hi) || ({1'b0, in_shamt} >= W2_L);
          src_r   = sat0 ? {W2{in_arith & in_mant[WIDTH-1]}} : {in_mant, 2'b00};
          src_st  = sat0 & (|in_mant);
          src_sh  = sat0 ? '0 : in_shamt;
          src_sat = sat0;
          src_ar  = in_arith;
          src_tag = in_tag;
        end
      end else begin : g_next
        always_comb begin
          src_r   = r_q[gi-1];
          src_st  = st_q[gi-1];
          src_sh  = sh_q[gi-1];
          src_sat = sat_q[gi-1];
          src_ar  = ar_q[gi-1];
          src_tag = tag_q[gi-1];
        end
      end

      logic [SHAMT_W-1:0]    amt;
      logic signed [W2-1:0]  ash;
      logic [W2-1:0]         lsh;
      logic [W2-1:0]         nxt_r;
      logic                  lost;

      assign amt   = src_sat ? '0 : (src_sh & MASK);
      // The signed shift gets its own signal. In a mixed-sign ternary the
      // operator would lose its signedness and zero-fill.
      assign ash   = $signed(src_r) >>> amt;
      assign lsh   = src_r >> amt;
      assign nxt_r = src_ar ? ash : lsh;
      // Bits pushed past the LSB by this stage's partial shift
      assign lost  = |(src_r & ~({W2{1'b1}} << amt));

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_q[gi]   <= '0;
          st_q[gi]  <= 1'b0;
          sh_q[gi]  <= '0;
          sat_q[gi] <= 1'b0;
          ar_q[gi]  <= 1'b0;
          tag_q[gi] <= '0;
        end else if (load[gi]) begin
          r_q[gi]   <= nxt_r;
          st_q[gi]  <= src_st | lost;
          sh_q[gi]  <= src_sh & ~MASK;
          sat_q[gi] <= src_sat;
          ar_q[gi]  <= src_ar;
          tag_q[gi] <= src_tag;
        end
      end
    end
  endgenerate

  assign out_valid  = valid_q[LATENCY-1];
  assign out_mant   = r_q[LATENCY-1][W2-1:2];
  assign out_guard  = r_q[LATENCY-1][1];
  assign out_round  = r_q[LATENCY-1][0];
  assign out_sticky = st_q[LATENCY-1];
  assign out_tag    = tag_q[LATENCY-1];

endmodule

// File: tb/tb_align_shifter_pipe.sv
module tb_align_shifter_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [23:0] in_mant = '0;
  logic [4:0]  in_shamt = '0;
  logic [2:0]  in_exp_hi = '0;
  logic        in_arith = 1'b0;
  logic [3:0]  in_tag = '0;
  logic        out_ready = 1'b1;

  // Index 0: LATENCY=2, 1: LATENCY=1, 2: LATENCY=5
  logic        ir [3];
  logic        ov [3];
  logic [23:0] om [3];
  logic        og [3];
  logic        orr[3];
  logic        os [3];
  logic [3:0]  ot [3];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  align_shifter_pipe #(.LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]),
    .in_mant(in_mant), .in_shamt(in_shamt), .in_exp_hi(in_exp_hi),
    .in_arith(in_arith), .in_tag(in_tag), .out_valid(ov[0]),
    .out_ready(out_ready), .out_mant(om[0]), .out_guard(og[0]),
    .out_round(orr[0]), .out_sticky(os[0]), .out_tag(ot[0]));

  align_shifter_pipe #(.LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]),
    .in_mant(in_mant), .in_shamt(in_shamt), .in_exp_hi(in_exp_hi),
    .in_arith(in_arith), .in_tag(in_tag), .out_valid(ov[1]),
    .out_ready(out_ready), .out_mant(om[1]), .out_guard(og[1]),
    .out_round(orr[1]), .out_sticky(os[1]), .out_tag(ot[1]));

  align_shifter_pipe #(.LATENCY(5)) u_l5 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]),
    .in_mant(in_mant), .in_shamt(in_shamt), .in_exp_hi(in_exp_hi),
    .in_arith(in_arith), .in_tag(in_tag), .out_valid(ov[2]),
    .out_ready(out_ready), .out_mant(om[2]), .out_guard(og[2]),
    .out_round(orr[2]), .out_sticky(os[2]), .out_tag(ot[2]));

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : ((d == 1) ? 1 : 5);
  endfunction

  task automatic set_op(input logic [23:0] m, input logic [4:0] sh,
                        input logic [2:0] eh, input logic ar, input logic [3:0] tg);
    in_valid  = 1'b1;
    in_mant   = m;
    in_shamt  = sh;
    in_exp_hi = eh;
    in_arith  = ar;
    in_tag    = tg;
  endtask

  // Called at posedge+1 with the operand already on the inputs and the pipe
  // drained. Returns the first result seen on DUT d and the number of
  // negedges waited after the transfer edge.
  task automatic run_one(input int d, output logic ok, output int n,
                         output logic [23:0] m, output logic [2:0] grs,
                         output logic [3:0] tg);
    ok = 1'b0; m = '0; grs = '0; tg = '0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (n = 0; n < 12; n++) begin
      @(negedge clk);
      if (ov[d]) begin
        ok  = 1'b1;
        m   = om[d];
        grs = {og[d], orr[d], os[d]};
        tg  = ot[d];
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (ov[d] !== 1'b0 || om[d] !== 24'h0 || {og[d], orr[d], os[d]} !== 3'b000 || ot[d] !== 4'h0) begin
        failures++;
        $display("FAIL reset_state dut=%0d valid=%b mant=%h grs=%b%b%b tag=%h want all zero",
                 d, ov[d], om[d], og[d], orr[d], os[d], ot[d]);
      end
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (ir[d] !== 1'b1 || ov[d] !== 1'b0) begin
        failures++;
        $display("FAIL reset_ready dut=%0d in_ready=%b out_valid=%b want 1/0", d, ir[d], ov[d]);
      end
    end
    $display("reset: done");
  endtask

  // Directed single-operand vectors on the LATENCY=2 instance
  task automatic test_vectors();
    logic [23:0] vm [9]  = '{24'h800001, 24'h800001, 24'h800001, 24'h000004, 24'h000004,
                             24'hF00000, 24'hF00000, 24'h800001, 24'h800001};
    logic [4:0]  vs [9]  = '{5'd1, 5'd3, 5'd0, 5'd0, 5'd26, 5'd4, 5'd4, 5'd25, 5'd31};
    logic [2:0]  ve [9]  = '{3'b000, 3'b000, 3'b000, 3'b010, 3'b000, 3'b000, 3'b001, 3'b000, 3'b000};
    logic        va [9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [23:0] em [9]  = '{24'h400000, 24'h100000, 24'h800001, 24'h000000, 24'h000000,
                             24'hFF0000, 24'hFFFFFF, 24'h000000, 24'h000000};
    logic [2:0]  eg [9]  = '{3'b100, 3'b001, 3'b000, 3'b001, 3'b001, 3'b000, 3'b111, 3'b011, 3'b001};
    logic ok; int n; logic [23:0] m; logic [2:0] grs; logic [3:0] tg;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk);
      #1 set_op(vm[i], vs[i], ve[i], va[i], 4'(i + 3));
      run_one(0, ok, n, m, grs, tg);
      checks++;
      if (!ok || m !== em[i] || grs !== eg[i] || tg !== 4'(i + 3)) begin
        failures++;
        $display("FAIL vector_%0d got ok=%b mant=%h grs=%b tag=%h want mant=%h grs=%b tag=%h",
                 i, ok, m, grs, tg, em[i], eg[i], 4'(i + 3));
      end
      $display("vector %0d: mant=%h shamt=%0d exp_hi=%b arith=%b -> mant=%h grs=%b tag=%h",
               i, vm[i], vs[i], ve[i], va[i], m, grs, tg);
      @(negedge clk);
    end
  endtask

  task automatic test_latency();
    logic ok; int n; logic [23:0] m; logic [2:0] grs; logic [3:0] tg;
    for (int d = 0; d < 3; d++) begin
      @(posedge clk);
      #1 set_op(24'h800001, 5'd2, 3'b000, 1'b0, 4'hA);
      run_one(d, ok, n, m, grs, tg);
      checks++;
      if (!ok || n !== lat_of(d) - 1 || m !== 24'h200000 || grs !== 3'b010 || tg !== 4'hA) begin
        failures++;
        $display("FAIL latency dut=%0d ok=%b wait=%0d mant=%h grs=%b tag=%h want wait=%0d mant=200000 grs=010 tag=a",
                 d, ok, n, m, grs, tg, lat_of(d) - 1);
      end
      $display("latency: dut=%0d waited %0d extra cycles, mant=%h", d, n, m);
      repeat (6) @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] em [4] = '{24'h800001, 24'h400000, 24'h200000, 24'h100000};
    logic [2:0]  eg [4] = '{3'b000, 3'b100, 3'b010, 3'b001};
    int n;
    @(posedge clk);
    #1;
    fork
      begin
        for (int k = 0; k < 4; k++) begin
          set_op(24'h800001, 5'(k), 3'b000, 1'b0, 4'(k));
          @(posedge clk);
          #1;
        end
        in_valid = 1'b0;
      end
      begin
        for (n = 0; n < 20; n++) begin
          @(negedge clk);
          if (ov[0]) break;
        end
        for (int k = 0; k < 4; k++) begin
          if (k > 0) @(negedge clk);
          checks++;
          if (ov[0] !== 1'b1 || om[0] !== em[k] || {og[0], orr[0], os[0]} !== eg[k] || ot[0] !== 4'(k)) begin
            failures++;
            $display("FAIL back_to_back_%0d valid=%b mant=%h grs=%b%b%b tag=%h want 1 %h %b %h",
                     k, ov[0], om[0], og[0], orr[0], os[0], ot[0], em[k], eg[k], 4'(k));
          end
          $display("back_to_back %0d: mant=%h tag=%h", k, om[0], ot[0]);
        end
      end
    join
    repeat (4) @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [23:0] vm [8] = '{24'h800001, 24'h800001, 24'h800001, 24'h800001,
                            24'h800001, 24'h800001, 24'h000004, 24'hF00000};
    logic [4:0]  vs [8] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd0, 5'd4};
    logic [2:0]  ve [8] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd0};
    logic        va [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [23:0] em [8] = '{24'h800001, 24'h400000, 24'h200000, 24'h100000,
                            24'h080000, 24'h040000, 24'h000000, 24'hFF0000};
    logic [2:0]  eg [8] = '{3'b000, 3'b100, 3'b010, 3'b001, 3'b001, 3'b001, 3'b001, 3'b000};
    int idx = 0;
    logic saw_block = 1'b0;
    logic held = 1'b0;
    logic [32:0] held_val = '0;
    @(posedge clk);
    #1;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          logic rdy;
          set_op(vm[i], vs[i], ve[i], va[i], 4'(i));
          for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            rdy = ir[0];
            if (!rdy) saw_block = 1'b1;
            @(posedge clk);
            #1;
            if (rdy) break;
          end
        end
        in_valid = 1'b0;
      end
      begin
        for (int cyc = 0; cyc < 400 && idx < 8; cyc++) begin
          out_ready = (cyc < 4) ? 1'b0 : 1'($urandom_range(0, 1));
          @(negedge clk);
          if (held) begin
            checks++;
            if (ov[0] !== 1'b1 || {om[0], og[0], orr[0], os[0], ot[0]} !== held_val) begin
              failures++;
              $display("FAIL stall_stable cyc=%0d valid=%b out=%h want held %h",
                       cyc, ov[0], {om[0], og[0], orr[0], os[0], ot[0]}, held_val);
            end
          end
          held = ov[0] & !out_ready;
          held_val = {om[0], og[0], orr[0], os[0], ot[0]};
          if (ov[0] && out_ready) begin
            checks++;
            if (om[0] !== em[idx] || {og[0], orr[0], os[0]} !== eg[idx] || ot[0] !== 4'(idx)) begin
              failures++;
              $display("FAIL bp_result_%0d mant=%h grs=%b%b%b tag=%h want %h %b %h",
                       idx, om[0], og[0], orr[0], os[0], ot[0], em[idx], eg[idx], 4'(idx));
            end
            $display("backpressure %0d: mant=%h tag=%h", idx, om[0], ot[0]);
            idx++;
          end
          @(posedge clk);
          #1;
        end
      end
    join
    out_ready = 1'b1;
    checks++;
    if (idx !== 8) begin
      failures++;
      $display("FAIL bp_count got %0d results want 8", idx);
    end
    checks++;
    if (saw_block !== 1'b1) begin
      failures++;
      $display("FAIL bp_in_ready_drop saw_block=%b want 1", saw_block);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_midflight(input int d);
    int stale = 0;
    logic ok; int n; logic [23:0] m; logic [2:0] grs; logic [3:0] tg;
    do_reset();
    out_ready = 1'b0;
    set_op(24'h800001, 5'd1, 3'b000, 1'b0, 4'h1);
    @(posedge clk);
    #1 set_op(24'h800001, 5'd3, 3'b000, 1'b0, 4'h2);
    @(posedge clk);
    #1 in_valid = 1'b0;
    checks++;
    if (ov[d] !== (lat_of(d) <= 2)) begin
      failures++;
      $display("FAIL midflight_pre dut=%0d out_valid=%b want %b", d, ov[d], lat_of(d) <= 2);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (ov[d] !== 1'b0 || ir[d] !== 1'b1 || ot[d] !== 4'h0) begin
      failures++;
      $display("FAIL midflight_async dut=%0d out_valid=%b in_ready=%b tag=%h want 0 1 0", d, ov[d], ir[d], ot[d]);
    end
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (ov[d]) stale++;
    end
    checks++;
    if (stale !== 0) begin
      failures++;
      $display("FAIL midflight_stale dut=%0d stale=%0d want 0", d, stale);
    end
    @(posedge clk);
    #1 set_op(24'h800001, 5'd2, 3'b000, 1'b0, 4'h9);
    run_one(d, ok, n, m, grs, tg);
    checks++;
    if (!ok || m !== 24'h200000 || grs !== 3'b010 || tg !== 4'h9) begin
      failures++;
      $display("FAIL midflight_next dut=%0d ok=%b mant=%h grs=%b tag=%h want 200000 010 9", d, ok, m, grs, tg);
    end
    $display("reset_midflight: dut=%0d stale=%0d next mant=%h tag=%h", d, stale, m, tg);
    repeat (6) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_vectors();
    test_latency();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight(0);
    test_reset_midflight(1);
    test_reset_midflight(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/align_shifter_pipe.md
Name: align_shifter_pipe

Overview:
Parametrised, pipelined mantissa alignment shifter for the FP adder datapaths (fp32 and wider).
- Right-shifts the smaller operand's significand by the exponent difference.
- Saturates when the exponent difference overflows the shift field.
- Produces guard, round and sticky bits for the rounding stage.
- Optional arithmetic (sign-fill) mode for two's-complement significands.
- Valid/ready handshake with full backpressure; a sideband tag travels with each operand.

Parameters:
WIDTH, 24, significand width in bits (≥4)
SHAMT_W, 5, shift-amount field width; 2**SHAMT_W ≥ WIDTH+2 required
EXP_HI_W, 3, width of upper exponent-difference bits that force saturation
LATENCY, 2, register stages (1..SHAMT_W); each stage resolves ceil(SHAMT_W/LATENCY) shift bits, MSB first
TAG_W, 4, sideband tag width (≥1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
in_valid  in  1  operand valid
in_ready  out  1  shifter can accept operand
in_mant  in  WIDTH  significand to align
in_shamt  in  SHAMT_W  shift amount (low exponent-difference bits)
in_exp_hi  in  EXP_HI_W  upper exponent-difference bits; any 1 forces saturation
in_arith  in  1  1 = fill with in_mant[WIDTH-1], 0 = fill with zeros
in_tag  in  TAG_W  sideband, passed through unchanged
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_mant  out  WIDTH  aligned significand
out_guard  out  1  first bit below out_mant LSB
out_round  out  1  second bit below out_mant LSB
out_sticky  out  1  OR of all discarded bits below round
out_tag  out  TAG_W  tag of this result

Behaviour:
- Extended vector E = {in_mant, 2'b00}, WIDTH+2 bits.
- Effective shift S:
  - in_exp_hi != 0 or in_shamt ≥ WIDTH+2 → saturated, S = WIDTH+2.
  - Otherwise S = in_shamt.
- Result R = E shifted right by S, vacated MSBs filled per in_arith.
  - {out_mant, out_guard, out_round} = R.
  - out_sticky = OR of the S bits shifted out of E's LSB end.
- Saturated, logical: out_mant = 0, guard = round = 0, sticky = |in_mant.
- Saturated, arith: out_mant = all copies of in_mant[WIDTH-1], guard = round = that sign bit, sticky = |in_mant.
- S = 0: out_mant = in_mant, guard = round = sticky = 0.
- Sticky is accumulated stage by stage. Each stage ORs in the bits it discards, so no stage needs the full lost-bit vector.
- Pipeline: LATENCY stage slots, each with a valid bit, carrying partial R, partial sticky, remaining shamt, saturate flag, arith, tag.
  - Saturate flag and arith are computed and latched at stage 0 and travel with the operand.
  - A slot advances when the next slot is empty or is itself advancing. The last slot advances when out_ready.
  - in_ready = !valid[0] | advance[0] (combinational from out_ready through the chain).
  - Transfers occur on in_valid & in_ready and on out_valid & out_ready.
  - Latency: LATENCY cycles from input transfer to out_valid when unstalled. Throughput 1/cycle.
  - No bubbles are inserted while out_ready is held high.
- Stall: while out_valid & !out_ready, all out_* are stable. No operand is dropped or duplicated, and order is preserved.
- out_* other than out_valid are don't-care when out_valid = 0. The implementation holds the last values.
- Reset (async assert, sync deassert handled by top): all valid bits clear, so out_valid = 0.
  - out_mant, out_guard, out_round, out_sticky and out_tag reset to 0.
  - in_ready = 1 from the first cycle after reset.
  - Reset mid-operation discards all in-flight operands. No output appears for them.
- Inputs are sampled only on transfer. Changes on in_* while in_ready = 0 have no effect.

Test Plan:
- Basic (LATENCY=2): in_mant=0x800001, shamt=1, logical → 2 cycles later: out_mant=0x400000, guard=1, round=0, sticky=0, tag matched.
- Sticky: in_mant=0x800001, shamt=3 → out_mant=0x100000, guard=0, round=0, sticky=1. Same input with shamt=0 → out_mant=0x800001, grs=000.
- Saturation: shamt=0, exp_hi=3'b010, in_mant=0x000004 → out_mant=0, guard=0, round=0, sticky=1. Also shamt=26 with exp_hi=0 → same result.
- Arithmetic: in_mant=0xF00000, arith=1, shamt=4 → out_mant=0xFF0000, grs=000. Same operand with exp_hi≠0 → out_mant=0xFFFFFF, guard=1, round=1, sticky=1.
- Backpressure: stream 8 tagged operands (tags 0..7) with out_ready random at 50%.
  - All 8 results arrive in order with correct values.
  - Outputs are stable during stalls.
  - in_ready drops once the pipe is full.
- Reset mid-flight: assert rst with 2 operands in the pipe → out_valid=0 immediately, no stale results after deassert, and the next operand is processed correctly. Repeat for LATENCY=1 and LATENCY=5.
